mme_ctrl: RTL and testbench

MME_CTRL -- requirements
Module: mme_ctrl

---
 rtl/mme_ctrl.sv | 123 ++++++++++++
 tb/tb_mme_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mme_ctrl.sv
// Sequencer for a 4x4x4 block matrix-multiply engine: streams A/B tiles through
// the read DMA, pulses the array once per K block, then writes C back.
module mme_ctrl #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  mat_width,
  input  logic [ADDR_W-1:0] mat_a_addr,
  input  logic [ADDR_W-1:0] mat_b_addr,
  input  logic [ADDR_W-1:0] mat_c_addr,
  output logic              busy,
  output logic              done,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic              rd_done,
  output logic              rd_sel,
  output logic              arr_clr,
  output logic              arr_go,
  input  logic              arr_done,
  output logic              wr_req,
  output logic [ADDR_W-1:0] wr_addr,
  input  logic              wr_ack,
  input  logic              wr_done,
  output logic [3:0]        dbg_state
);

  localparam int BW = CNT_W - 2;

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_CLR    = 4'd1;
  localparam logic [3:0] S_RD_A   = 4'd2;
  localparam logic [3:0] S_WT_A   = 4'd3;
  localparam logic [3:0] S_RD_B   = 4'd4;
  localparam logic [3:0] S_WT_B   = 4'd5;
  localparam logic [3:0] S_CMP    = 4'd6;
  localparam logic [3:0] S_WT_CMP = 4'd7;
  localparam logic [3:0] S_WR_C   = 4'd8;
  localparam logic [3:0] S_WT_C   = 4'd9;
  localparam logic [3:0] S_FIN    = 4'd10;

  // Handshake: a request output stays high with stable address/select until the
  // cycle its ack is sampled high; the request drops on the following edge.

  logic [3:0]        state;
  logic [3:0]        state_nxt;
  logic [BW-1:0]     nblk;
  logic [BW-1:0]     blk;
  logic [ADDR_W-1:0] a_base;
  logic [ADDR_W-1:0] b_base;
  logic [ADDR_W-1:0] c_base;
  logic              last_blk;
  logic [ADDR_W-1:0] blk_off;
  logic              width_unused;

  // Widths are whole multiples of 4; the low two bits carry no information.
  assign width_unused = ^mat_width[1:0];

  assign last_blk  = (blk == nblk - BW'(1));
  assign blk_off   = ADDR_W'({blk, 6'b000000});
  assign rd_addr   = (rd_sel ? b_base : a_base) + blk_off;
  assign wr_addr   = c_base;
  assign dbg_state = state;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (start) state_nxt = S_CLR;
      S_CLR:    state_nxt = (nblk != '0) ? S_RD_A : S_WR_C;
      S_RD_A:   if (rd_ack) state_nxt = S_WT_A;
      S_WT_A:   if (rd_done) state_nxt = S_RD_B;
      S_RD_B:   if (rd_ack) state_nxt = S_WT_B;
      S_WT_B:   if (rd_done) state_nxt = S_CMP;
      S_CMP:    state_nxt = S_WT_CMP;
      S_WT_CMP: if (arr_done) state_nxt = last_blk ? S_WR_C : S_RD_A;
      S_WR_C:   if (wr_ack) state_nxt = S_WT_C;
      S_WT_C:   if (wr_done) state_nxt = S_FIN;
      S_FIN:    state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      nblk    <= '0;
      blk     <= '0;
      a_base  <= '0;
      b_base  <= '0;
      c_base  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_req  <= 1'b0;
      rd_sel  <= 1'b0;
      wr_req  <= 1'b0;
      arr_clr <= 1'b0;
      arr_go  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == S_IDLE && start) begin
        a_base <= mat_a_addr;
        b_base <= mat_b_addr;
        c_base <= mat_c_addr;
        nblk   <= mat_width[CNT_W-1:2];
        blk    <= '0;
        done   <= 1'b0;
      end
      if (state == S_WT_CMP && arr_done && !last_blk) blk <= blk + BW'(1);
      if (state_nxt == S_FIN) done <= 1'b1;
      // Outputs decode the next state so they flip together with the state flops.
      busy    <= (state_nxt != S_IDLE);
      rd_req  <= (state_nxt == S_RD_A) || (state_nxt == S_RD_B);
      rd_sel  <= (state_nxt == S_RD_B);
      wr_req  <= (state_nxt == S_WR_C);
      arr_clr <= (state_nxt == S_CLR);
      arr_go  <= (state_nxt == S_CMP);
    end
  end

endmodule

// File: tb/tb_mme_ctrl.sv
// Directed bench for mme_ctrl: a DMA/array responder, an access monitor and a
// sequence of hand-computed jobs checked against an expected queue.
module tb_mme_ctrl;

  localparam int ADDR_W = 32;
  localparam int CNT_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic [CNT_W-1:0]  mat_width;
  logic [ADDR_W-1:0] mat_a_addr;
  logic [ADDR_W-1:0] mat_b_addr;
  logic [ADDR_W-1:0] mat_c_addr;
  logic              busy;
  logic              done;
  logic              rd_req;
  logic [ADDR_W-1:0] rd_addr;
  logic              rd_ack;
  logic              rd_done;
  logic              rd_sel;
  logic              arr_clr;
  logic              arr_go;
  logic              arr_done;
  logic              wr_req;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_ack;
  logic              wr_done;
  logic [3:0]        dbg_state;

  int n_checks = 0;
  int n_fail   = 0;
  int rd_dly   = 0;
  int n_go     = 0;
  int n_clr    = 0;

  logic [ADDR_W:0]   exp_q[$];
  logic [ADDR_W:0]   obs_q[$];
  logic [ADDR_W-1:0] wr_q[$];

  mme_ctrl #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .mat_width(mat_width),
    .mat_a_addr(mat_a_addr), .mat_b_addr(mat_b_addr), .mat_c_addr(mat_c_addr),
    .busy(busy), .done(done), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_ack(rd_ack), .rd_done(rd_done), .rd_sel(rd_sel), .arr_clr(arr_clr),
    .arr_go(arr_go), .arr_done(arr_done), .wr_req(wr_req), .wr_addr(wr_addr),
    .wr_ack(wr_ack), .wr_done(wr_done), .dbg_state(dbg_state)
  );

  // clock / watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // responder: read ack after rd_dly cycles then rd_done, array/write answer next cycle
  initial begin
    bit rd_pend, arr_pend, wr_pend;
    int rd_wait;
    rd_pend = 0; arr_pend = 0; wr_pend = 0; rd_wait = 0;
    rd_ack = 0; rd_done = 0; arr_done = 0; wr_ack = 0; wr_done = 0;
    forever begin
      @(posedge clk); #1;
      rd_ack = 0; rd_done = 0; arr_done = 0; wr_ack = 0; wr_done = 0;
      if (!rst_n) begin
        rd_pend = 0; arr_pend = 0; wr_pend = 0; rd_wait = 0;
      end else begin
        if (rd_pend) begin rd_done = 1; rd_pend = 0; end
        if (rd_req) begin
          if (rd_wait >= rd_dly) begin rd_ack = 1; rd_wait = 0; rd_pend = 1; end
          else rd_wait++;
        end
        if (arr_pend) begin arr_done = 1; arr_pend = 0; end
        if (arr_go) arr_pend = 1;
        if (wr_pend) begin wr_done = 1; wr_pend = 0; end
        if (wr_req) begin wr_ack = 1; wr_pend = 1; end
      end
    end
  end

  // monitor: logs accepted transfers, counts pulses, checks request hold
  logic              prv_req = 1'b0;
  logic              prv_ack = 1'b0;
  logic              prv_sel = 1'b0;
  logic [ADDR_W-1:0] prv_addr = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (rd_req && prv_req && !prv_ack) begin
        check("rd_addr_hold", rd_addr, prv_addr);
        check("rd_sel_hold", rd_sel, prv_sel);
      end
      if (rd_req && rd_ack) obs_q.push_back({rd_sel, rd_addr});
      if (wr_req && wr_ack) wr_q.push_back(wr_addr);
      if (arr_go) n_go++;
      if (arr_clr) n_clr++;
      prv_req  = rd_req;
      prv_ack  = rd_ack;
      prv_sel  = rd_sel;
      prv_addr = rd_addr;
    end else begin
      prv_req = 1'b0;
    end
  end

  // driver tasks
  task automatic start_job(input logic [CNT_W-1:0] w, input logic [ADDR_W-1:0] a,
                           input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    @(negedge clk);
    obs_q.delete(); wr_q.delete(); n_go = 0; n_clr = 0;
    mat_width = w; mat_a_addr = a; mat_b_addr = b; mat_c_addr = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("done_cleared", done, 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("done_timeout", done, 1);
    @(negedge clk);
    check("busy_idle", busy, 0);
    check("done_sticky", done, 1);
    repeat (2) @(negedge clk);
  endtask

  // scoreboard: expected read stream, pulse counts and the single C write
  task automatic verify_job(input int nb, input logic [ADDR_W-1:0] a,
                            input logic [ADDR_W-1:0] b, input logic [ADDR_W-1:0] c);
    exp_q.delete();
    for (int i = 0; i < nb; i++) begin
      exp_q.push_back({1'b0, a + ADDR_W'(i * 64)});
      exp_q.push_back({1'b1, b + ADDR_W'(i * 64)});
    end
    check("rd_count", obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check("rd_sel_addr", obs_q[i], exp_q[i]);
    check("go_count", n_go, nb);
    check("clr_count", n_clr, 1);
    check("wr_count", wr_q.size(), 1);
    if (wr_q.size() > 0) check("wr_addr", wr_q[0], c);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_state"}, dbg_state, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_rd_req"}, rd_req, 0);
    check({tag, "_wr_req"}, wr_req, 0);
    check({tag, "_arr_clr"}, arr_clr, 0);
    check({tag, "_arr_go"}, arr_go, 0);
    check({tag, "_rd_addr"}, rd_addr, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; start = 1'b0; mat_width = '0;
    mat_a_addr = '0; mat_b_addr = '0; mat_c_addr = '0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // single block
    start_job(8'd4, 32'h0, 32'h1000, 32'h2000);
    check("arr_clr_pulse", arr_clr, 1);
    wait_done();
    verify_job(1, 32'h0, 32'h1000, 32'h2000);

    // four blocks
    start_job(8'd16, 32'h0, 32'h1000, 32'h2000);
    wait_done();
    verify_job(4, 32'h0, 32'h1000, 32'h2000);

    // slow read ack with config disturbed during the wait
    rd_dly = 5;
    start_job(8'd4, 32'h300, 32'h700, 32'h900);
    n = 0;
    while (!rd_req && n < 20) begin @(negedge clk); n++; end
    check("rd_req_seen", rd_req, 1);
    repeat (2) @(negedge clk);
    mat_a_addr = 32'h5000; mat_b_addr = 32'h6000; mat_c_addr = 32'h7000;
    wait_done();
    verify_job(1, 32'h300, 32'h700, 32'h900);
    rd_dly = 0;

    // start re-pulsed during WT_B is ignored
    start_job(8'd4, 32'h0, 32'h1000, 32'h2000);
    n = 0;
    while (!(rd_req && rd_ack && rd_sel) && n < 50) begin @(negedge clk); n++; end
    check("b_ack_seen", rd_req && rd_ack && rd_sel, 1);
    @(negedge clk);
    mat_width = 8'd8; mat_a_addr = 32'h8000; mat_b_addr = 32'h9000; mat_c_addr = 32'hA000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    verify_job(1, 32'h0, 32'h1000, 32'h2000);

    // zero blocks: clear then write zeros
    start_job(8'd2, 32'h40, 32'h1040, 32'h3000);
    wait_done();
    verify_job(0, 32'h40, 32'h1040, 32'h3000);

    // reset during WT_CMP, then a fresh job
    start_job(8'd12, 32'h100, 32'h1100, 32'h2100);
    n = 0;
    while (!arr_go && n < 50) begin @(negedge clk); n++; end
    check("arr_go_seen", arr_go, 1);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("mid_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_idle_busy", busy, 0);
    check("post_rst_idle_rd", rd_req, 0);
    start_job(8'd4, 32'h400, 32'h1400, 32'h2400);
    wait_done();
    verify_job(1, 32'h400, 32'h1400, 32'h2400);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
